// File: rtl/lcd_write_arbiter.sv
// Shared-access controller for a 2x16 HD44780-style LCD: power-up init, then
// round-robin arbitration of single-character writes from two requesters.
module lcd_write_arbiter #(
    parameter int unsigned PWRUP_CYC  = 32'd70,
    parameter int unsigned E_HIGH_CYC = 32'd2,
    parameter int unsigned CMD_GAP    = 32'd30,
    parameter int unsigned CLR_GAP    = 32'd200
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       REQ0_VALID,
    input  logic       REQ0_ROW,
    input  logic [3:0] REQ0_COL,
    input  logic [7:0] REQ0_CHAR,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic       REQ1_ROW,
    input  logic [3:0] REQ1_COL,
    input  logic [7:0] REQ1_CHAR,
    output logic       REQ1_READY,
    output logic       INIT_DONE,
    output logic       BUSY,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_CHAR  = 3'd4
    } state_t;

    localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_CYC - 32'd1);
    localparam logic [15:0] E_HIGH     = 16'(E_HIGH_CYC);
    localparam logic [15:0] CMD_LAST   = 16'(CMD_GAP - 32'd1);
    localparam logic [15:0] CLR_LAST   = 16'(CLR_GAP - 32'd1);

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h3C;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    // Only the clear-display instruction needs the long settle time.
    function automatic logic [15:0] write_last(input logic rs, input logic [7:0] data);
        return (!rs && (data == 8'h01)) ? CLR_LAST : CMD_LAST;
    endfunction

    function automatic logic [7:0] addr_cmd(input logic row, input logic [3:0] col);
        return {1'b1, row, 2'b00, col};
    endfunction

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [15:0] last_r;
    logic [1:0]  init_idx_r;
    logic        prio_r;
    logic [7:0]  char_r;
    logic        init_done_r;
    logic        busy_r;
    logic        lcd_e_r;
    logic        lcd_rs_r;
    logic [7:0]  lcd_data_r;

    logic        accept_s;
    logic        grant_s;
    logic        sel_row_s;
    logic [3:0]  sel_col_s;
    logic [7:0]  sel_char_s;
    logic        wr_end_s;
    logic        e_next_s;

    // Round-robin grant; prio_r names the requester preferred on a tie.
    always_comb begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (REQ0_VALID && REQ1_VALID) begin
                accept_s = 1'b1;
                grant_s  = prio_r;
            end else if (REQ0_VALID) begin
                accept_s = 1'b1;
                grant_s  = 1'b0;
            end else if (REQ1_VALID) begin
                accept_s = 1'b1;
                grant_s  = 1'b1;
            end else begin
                accept_s = 1'b0;
                grant_s  = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
            grant_s  = 1'b0;
        end
    end

    // Field mux for the granted requester and bus-write phase decode.
    always_comb begin
        sel_row_s  = REQ0_ROW;
        sel_col_s  = REQ0_COL;
        sel_char_s = REQ0_CHAR;
        if (grant_s) begin
            sel_row_s  = REQ1_ROW;
            sel_col_s  = REQ1_COL;
            sel_char_s = REQ1_CHAR;
        end else begin
            sel_row_s  = REQ0_ROW;
            sel_col_s  = REQ0_COL;
            sel_char_s = REQ0_CHAR;
        end
        wr_end_s = (cnt_r == last_r);
        e_next_s = (cnt_r < E_HIGH);
    end

    // Main sequencer: every LCD pin and status flag is a register here.
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_r     <= ST_PWRUP;
            cnt_r       <= 16'd0;
            last_r      <= 16'd0;
            init_idx_r  <= 2'd0;
            prio_r      <= 1'b0;
            char_r      <= 8'h00;
            init_done_r <= 1'b0;
            busy_r      <= 1'b1;
            lcd_e_r     <= 1'b0;
            lcd_rs_r    <= 1'b0;
            lcd_data_r  <= 8'h00;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    if (cnt_r == PWRUP_LAST) begin
                        state_r    <= ST_INIT;
                        init_idx_r <= 2'd0;
                        cnt_r      <= 16'd0;
                        lcd_e_r    <= 1'b0;
                        lcd_rs_r   <= 1'b0;
                        lcd_data_r <= init_cmd(2'd0);
                        last_r     <= write_last(1'b0, init_cmd(2'd0));
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_INIT: begin
                    if (!wr_end_s) begin
                        cnt_r   <= cnt_r + 16'd1;
                        lcd_e_r <= e_next_s;
                    end else if (init_idx_r == 2'd3) begin
                        state_r     <= ST_IDLE;
                        init_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                        lcd_e_r     <= 1'b0;
                    end else begin
                        init_idx_r <= init_idx_r + 2'd1;
                        cnt_r      <= 16'd0;
                        lcd_e_r    <= 1'b0;
                        lcd_rs_r   <= 1'b0;
                        lcd_data_r <= init_cmd(init_idx_r + 2'd1);
                        last_r     <= write_last(1'b0, init_cmd(init_idx_r + 2'd1));
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_ADDR;
                        busy_r     <= 1'b1;
                        prio_r     <= ~grant_s;
                        char_r     <= sel_char_s;
                        cnt_r      <= 16'd0;
                        lcd_e_r    <= 1'b0;
                        lcd_rs_r   <= 1'b0;
                        lcd_data_r <= addr_cmd(sel_row_s, sel_col_s);
                        last_r     <= CMD_LAST;
                    end else begin
                        lcd_e_r <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (!wr_end_s) begin
                        cnt_r   <= cnt_r + 16'd1;
                        lcd_e_r <= e_next_s;
                    end else begin
                        state_r    <= ST_CHAR;
                        cnt_r      <= 16'd0;
                        lcd_e_r    <= 1'b0;
                        lcd_rs_r   <= 1'b1;
                        lcd_data_r <= char_r;
                        last_r     <= write_last(1'b1, char_r);
                    end
                end
                ST_CHAR: begin
                    if (!wr_end_s) begin
                        cnt_r   <= cnt_r + 16'd1;
                        lcd_e_r <= e_next_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        lcd_e_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_PWRUP;
                    cnt_r       <= 16'd0;
                    init_done_r <= 1'b0;
                    busy_r      <= 1'b1;
                    lcd_e_r     <= 1'b0;
                end
            endcase
        end
    end

    assign REQ0_READY = accept_s & ~grant_s;
    assign REQ1_READY = accept_s & grant_s;
    assign INIT_DONE  = init_done_r;
    assign BUSY       = busy_r;
    assign LCD_E      = lcd_e_r;
    assign LCD_RS     = lcd_rs_r;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = lcd_data_r;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: init timing, single and contended
// writes, reset during a write, and input changes after accept.
module tb_lcd_write_arbiter;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       REQ0_VALID, REQ0_ROW, REQ0_READY;
    logic [3:0] REQ0_COL;
    logic [7:0] REQ0_CHAR;
    logic       REQ1_VALID, REQ1_ROW, REQ1_READY;
    logic [3:0] REQ1_COL;
    logic [7:0] REQ1_CHAR;
    logic       INIT_DONE, BUSY, LCD_E, LCD_RS, LCD_RW;
    logic [7:0] LCD_DATA;

    int checks = 0;
    int errors = 0;

    lcd_write_arbiter dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ0_VALID(REQ0_VALID), .REQ0_ROW(REQ0_ROW), .REQ0_COL(REQ0_COL),
        .REQ0_CHAR(REQ0_CHAR), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ROW(REQ1_ROW), .REQ1_COL(REQ1_COL),
        .REQ1_CHAR(REQ1_CHAR), .REQ1_READY(REQ1_READY),
        .INIT_DONE(INIT_DONE), .BUSY(BUSY), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_DATA(LCD_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point sits just after the falling edge.
    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    // Starts at the first cycle after reset release, ends on cycle 360.
    task automatic check_init(input string tag);
        int   e_pwr   = 0;
        int   e_tot   = 0;
        logic rs_or   = 1'b0;
        logic rdy_or  = 1'b0;
        logic done_or = 1'b0;
        for (int n = 0; n <= 360; n++) begin
            if (n < 360) begin
                if (LCD_E) e_tot++;
                if (LCD_E && (n < 70)) e_pwr++;
                rs_or   = rs_or | LCD_RS;
                rdy_or  = rdy_or | REQ0_READY | REQ1_READY;
                done_or = done_or | INIT_DONE;
            end
            case (n)
                0: begin
                    chk1({tag, "_rst_e"}, LCD_E, 1'b0);
                    chk8({tag, "_rst_data"}, LCD_DATA, 8'h00);
                    chk1({tag, "_rst_rw"}, LCD_RW, 1'b0);
                    chk1({tag, "_rst_done"}, INIT_DONE, 1'b0);
                    chk1({tag, "_rst_busy"}, BUSY, 1'b1);
                end
                69:  chk8({tag, "_c69_data"}, LCD_DATA, 8'h00);
                70: begin
                    chk8({tag, "_c70_data"}, LCD_DATA, 8'h3C);
                    chk1({tag, "_c70_e"}, LCD_E, 1'b0);
                end
                71:  chk1({tag, "_c71_e"}, LCD_E, 1'b1);
                72:  chk1({tag, "_c72_e"}, LCD_E, 1'b1);
                73:  chk1({tag, "_c73_e"}, LCD_E, 1'b0);
                99:  chk8({tag, "_c99_data"}, LCD_DATA, 8'h3C);
                100: chk8({tag, "_c100_data"}, LCD_DATA, 8'h0C);
                101: chk1({tag, "_c101_e"}, LCD_E, 1'b1);
                130: chk8({tag, "_c130_data"}, LCD_DATA, 8'h06);
                160: chk8({tag, "_c160_data"}, LCD_DATA, 8'h01);
                162: chk1({tag, "_c162_e"}, LCD_E, 1'b1);
                163: chk1({tag, "_c163_e"}, LCD_E, 1'b0);
                359: begin
                    chk8({tag, "_c359_data"}, LCD_DATA, 8'h01);
                    chk1({tag, "_c359_busy"}, BUSY, 1'b1);
                end
                360: begin
                    chk1({tag, "_c360_done"}, INIT_DONE, 1'b1);
                    chk1({tag, "_c360_busy"}, BUSY, 1'b0);
                end
                default: ;
            endcase
            if (n < 360) tick();
        end
        chki({tag, "_pwrup_e_cycles"}, e_pwr, 0);
        chki({tag, "_e_high_cycles"}, e_tot, 8);
        chk1({tag, "_rs_any"}, rs_or, 1'b0);
        chk1({tag, "_ready_any"}, rdy_or, 1'b0);
        chk1({tag, "_done_early"}, done_or, 1'b0);
    endtask

    // Starts one cycle after the accepting edge, ends on the following IDLE cycle.
    task automatic check_write(input string tag, input logic [7:0] addr, input logic [7:0] ch);
        int e_tot = 0;
        for (int m = 1; m <= 61; m++) begin
            if ((m < 61) && LCD_E) e_tot++;
            case (m)
                1: begin
                    chk8({tag, "_addr"}, LCD_DATA, addr);
                    chk1({tag, "_addr_rs"}, LCD_RS, 1'b0);
                    chk1({tag, "_addr_e0"}, LCD_E, 1'b0);
                    chk1({tag, "_ready0_low"}, REQ0_READY, 1'b0);
                    chk1({tag, "_ready1_low"}, REQ1_READY, 1'b0);
                    chk1({tag, "_busy"}, BUSY, 1'b1);
                end
                2:  chk1({tag, "_addr_e1"}, LCD_E, 1'b1);
                3:  chk1({tag, "_addr_e2"}, LCD_E, 1'b1);
                4:  chk1({tag, "_addr_e3"}, LCD_E, 1'b0);
                30: chk8({tag, "_addr_hold"}, LCD_DATA, addr);
                31: begin
                    chk8({tag, "_char"}, LCD_DATA, ch);
                    chk1({tag, "_char_rs"}, LCD_RS, 1'b1);
                    chk1({tag, "_char_e0"}, LCD_E, 1'b0);
                end
                32: chk1({tag, "_char_e1"}, LCD_E, 1'b1);
                34: chk1({tag, "_char_e3"}, LCD_E, 1'b0);
                60: chk1({tag, "_busy_end"}, BUSY, 1'b1);
                61: chk1({tag, "_idle"}, BUSY, 1'b0);
                default: ;
            endcase
            if (m < 61) tick();
        end
        chki({tag, "_e_high_cycles"}, e_tot, 4);
    endtask

    initial begin
        RESETN     = 1'b1;
        REQ0_VALID = 1'b0; REQ0_ROW = 1'b0; REQ0_COL = 4'd0; REQ0_CHAR = 8'h00;
        REQ1_VALID = 1'b0; REQ1_ROW = 1'b0; REQ1_COL = 4'd0; REQ1_CHAR = 8'h00;
        repeat (3) @(negedge CLK);
        #1;
        RESETN = 1'b0;

        check_init("init1");

        // Single write from requester 0.
        REQ0_ROW = 1'b1; REQ0_COL = 4'd5; REQ0_CHAR = 8'h41; REQ0_VALID = 1'b1;
        #1;
        chk1("t2_ready0", REQ0_READY, 1'b1);
        chk1("t2_ready1", REQ1_READY, 1'b0);
        tick();
        chk1("t2_ready0_single", REQ0_READY, 1'b0);
        REQ0_VALID = 1'b0;
        check_write("t2", 8'hC5, 8'h41);

        // Fields change right after accept; bus must show the captured values.
        REQ0_ROW = 1'b0; REQ0_COL = 4'd0; REQ0_CHAR = 8'h30; REQ0_VALID = 1'b1;
        #1;
        chk1("t6_ready0", REQ0_READY, 1'b1);
        tick();
        REQ0_CHAR = 8'h5A; REQ0_ROW = 1'b1; REQ0_COL = 4'd15; REQ0_VALID = 1'b0;
        check_write("t6", 8'h80, 8'h30);

        // Contention: requester 0 was granted last, so requester 1 goes first.
        REQ0_ROW = 1'b0; REQ0_COL = 4'd3;  REQ0_CHAR = 8'h61; REQ0_VALID = 1'b1;
        REQ1_ROW = 1'b1; REQ1_COL = 4'd15; REQ1_CHAR = 8'h62; REQ1_VALID = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk1($sformatf("t3_g%0d_ready0", g), REQ0_READY, (g % 2) == 1);
            chk1($sformatf("t3_g%0d_ready1", g), REQ1_READY, (g % 2) == 0);
            tick();
            if ((g % 2) == 0) check_write($sformatf("t3_g%0d", g), 8'hCF, 8'h62);
            else              check_write($sformatf("t3_g%0d", g), 8'h83, 8'h61);
        end

        // Reset while the character strobe is high; request stays pending.
        REQ0_VALID = 1'b0;
        REQ1_ROW = 1'b0; REQ1_COL = 4'd1; REQ1_CHAR = 8'h77;
        #1;
        chk1("t5_ready1", REQ1_READY, 1'b1);
        tick();
        repeat (31) tick();
        chk1("t5_pre_e", LCD_E, 1'b1);
        chk1("t5_pre_rs", LCD_RS, 1'b1);
        chk8("t5_pre_data", LCD_DATA, 8'h77);
        RESETN = 1'b1;
        #1;
        chk1("t5_rst_e", LCD_E, 1'b0);
        chk8("t5_rst_data", LCD_DATA, 8'h00);
        chk1("t5_rst_done", INIT_DONE, 1'b0);
        chk1("t5_rst_busy", BUSY, 1'b1);
        chk1("t5_rst_ready1", REQ1_READY, 1'b0);
        tick();
        tick();
        RESETN = 1'b0;

        check_init("init2");
        chk1("t4_ready1_first_idle", REQ1_READY, 1'b1);
        chk1("t4_ready0_first_idle", REQ0_READY, 1'b0);
        tick();
        REQ1_VALID = 1'b0;
        check_write("t5_served", 8'h81, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
